// File: rtl/cb_pkg.sv
// Shared state encoding and arithmetic helpers for the path-search sequencing controller.
package cb_pkg;

  typedef enum logic [3:0] {
    OCIOSO,
    INICIAR,
    ESPERA,
    AVALIAR,
    SELECIONAR,
    DESATIVAR,
    EXPANDIR,
    VIZINHO,
    ATUALIZAR,
    FIM_OK,
    FIM_FALHA
  } estado_e;

  // Unsigned add clamped to the largest value representable in 'largura' bits.
  function automatic logic [31:0] soma_saturada(input logic [31:0] a, input logic [31:0] b,
                                                input int unsigned largura);
    logic [32:0] soma;
    logic [32:0] maximo;
    soma   = {1'b0, a} + {1'b0, b};
    maximo = (33'd1 << largura) - 33'd1;
    return (soma > maximo) ? maximo[31:0] : soma[31:0];
  endfunction

endpackage

// File: rtl/controlador_busca_if.sv
// Evaluator and neighbour-source bus seen by the search controller (master side drives cb_*).
interface controlador_busca_if #(
  parameter int unsigned NUM_NA          = 4,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter int unsigned CUSTO_WIDTH     = 4
);
  logic [NUM_NA-1:0]                 aa_aprovado_in;
  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in;
  logic                              aa_tem_ativo_in;
  logic                              aa_tem_aprovado_in;
  logic                              aa_ocupado_in;
  logic                              aa_pronto_in;
  logic                              cb_atualizar_out;
  logic                              cb_desativar_out;
  logic [ADDR_WIDTH-1:0]             cb_endereco_out;
  logic [ADDR_WIDTH-1:0]             cb_anterior_out;
  logic [DISTANCIA_WIDTH-1:0]        cb_distancia_out;
  logic [CUSTO_WIDTH-1:0]            cb_menor_vizinho_out;
  logic                              cb_expandir_out;
  logic [ADDR_WIDTH-1:0]             cb_expandir_endereco_out;
  logic                              viz_valido_in;
  logic                              viz_vazio_in;
  logic [ADDR_WIDTH-1:0]             viz_endereco_in;
  logic [CUSTO_WIDTH-1:0]            viz_custo_in;
  logic [CUSTO_WIDTH-1:0]            viz_heuristica_in;
  logic                              viz_ultimo_in;
  logic                              cb_viz_pronto_out;

  modport master (
    input  aa_aprovado_in, aa_endereco_in, aa_distancia_in, aa_tem_ativo_in,
           aa_tem_aprovado_in, aa_ocupado_in, aa_pronto_in,
           viz_valido_in, viz_vazio_in, viz_endereco_in, viz_custo_in, viz_heuristica_in,
           viz_ultimo_in,
    output cb_atualizar_out, cb_desativar_out, cb_endereco_out, cb_anterior_out,
           cb_distancia_out, cb_menor_vizinho_out, cb_expandir_out, cb_expandir_endereco_out,
           cb_viz_pronto_out
  );

  modport slave (
    output aa_aprovado_in, aa_endereco_in, aa_distancia_in, aa_tem_ativo_in,
           aa_tem_aprovado_in, aa_ocupado_in, aa_pronto_in,
           viz_valido_in, viz_vazio_in, viz_endereco_in, viz_custo_in, viz_heuristica_in,
           viz_ultimo_in,
    input  cb_atualizar_out, cb_desativar_out, cb_endereco_out, cb_anterior_out,
           cb_distancia_out, cb_menor_vizinho_out, cb_expandir_out, cb_expandir_endereco_out,
           cb_viz_pronto_out
  );
endinterface

// File: rtl/controlador_busca_seletor_aprovado.sv
// Picks the lowest-index approved slot and muxes its address and distance off the flat buses.
module seletor_aprovado #(
  parameter int unsigned NUM_NA          = 4,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5
) (
  input  logic [NUM_NA-1:0]                 aprovado_i,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      endereco_i,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] distancia_i,
  output logic [NUM_NA-1:0]                 onehot_o,
  output logic [ADDR_WIDTH-1:0]             endereco_o,
  output logic [DISTANCIA_WIDTH-1:0]        distancia_o
);

  // Scan from the top down so the lowest approved index is the last to write.
  always_comb begin
    onehot_o    = '0;
    endereco_o  = '0;
    distancia_o = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (aprovado_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        endereco_o  = endereco_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        distancia_o = distancia_i[i*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/controlador_busca.sv
// Sequences the active-node evaluator: seed, select, retire, expand neighbours, report result.
module controlador_busca
  import cb_pkg::*;
#(
  parameter int unsigned NUM_NA          = 4,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter int unsigned CUSTO_WIDTH     = 4,
  parameter int unsigned WAIT_MAX        = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] origem_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  cb_ocupado_out,
  output logic                  cb_encontrado_out,
  output logic                  cb_falha_out,
  controlador_busca_if.master   bus
);

  localparam int unsigned CNT_WIDTH = $clog2(WAIT_MAX + 1);

  estado_e                    estado_q, estado_d;
  logic [ADDR_WIDTH-1:0]      origem_q, origem_d, destino_q, destino_d;
  logic [ADDR_WIDTH-1:0]      sel_end_q, sel_end_d, viz_end_q, viz_end_d;
  logic [DISTANCIA_WIDTH-1:0] sel_dist_q, sel_dist_d, viz_dist_q, viz_dist_d;
  logic [CUSTO_WIDTH-1:0]     viz_heur_q, viz_heur_d;
  logic                       ultimo_q, ultimo_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       encontrado_q, encontrado_d, falha_q, falha_d;

  logic [NUM_NA-1:0]          sel_onehot;
  logic [ADDR_WIDTH-1:0]      sel_endereco;
  logic [DISTANCIA_WIDTH-1:0] sel_distancia;

  seletor_aprovado #(
    .NUM_NA          (NUM_NA),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DISTANCIA_WIDTH (DISTANCIA_WIDTH)
  ) u_seletor (
    .aprovado_i  (bus.aa_aprovado_in),
    .endereco_i  (bus.aa_endereco_in),
    .distancia_i (bus.aa_distancia_in),
    .onehot_o    (sel_onehot),
    .endereco_o  (sel_endereco),
    .distancia_o (sel_distancia)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= OCIOSO;
      origem_q     <= '0;
      destino_q    <= '0;
      sel_end_q    <= '0;
      sel_dist_q   <= '0;
      viz_end_q    <= '0;
      viz_dist_q   <= '0;
      viz_heur_q   <= '0;
      ultimo_q     <= 1'b0;
      cnt_q        <= '0;
      encontrado_q <= 1'b0;
      falha_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      origem_q     <= origem_d;
      destino_q    <= destino_d;
      sel_end_q    <= sel_end_d;
      sel_dist_q   <= sel_dist_d;
      viz_end_q    <= viz_end_d;
      viz_dist_q   <= viz_dist_d;
      viz_heur_q   <= viz_heur_d;
      ultimo_q     <= ultimo_d;
      cnt_q        <= cnt_d;
      encontrado_q <= encontrado_d;
      falha_q      <= falha_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    origem_d     = origem_q;
    destino_d    = destino_q;
    sel_end_d    = sel_end_q;
    sel_dist_d   = sel_dist_q;
    viz_end_d    = viz_end_q;
    viz_dist_d   = viz_dist_q;
    viz_heur_d   = viz_heur_q;
    ultimo_d     = ultimo_q;
    cnt_d        = cnt_q;
    encontrado_d = encontrado_q;
    falha_d      = falha_q;

    bus.cb_atualizar_out         = 1'b0;
    bus.cb_desativar_out         = 1'b0;
    bus.cb_endereco_out          = '0;
    bus.cb_anterior_out          = '0;
    bus.cb_distancia_out         = '0;
    bus.cb_menor_vizinho_out     = '0;
    bus.cb_expandir_out          = 1'b0;
    bus.cb_expandir_endereco_out = '0;
    bus.cb_viz_pronto_out        = 1'b0;

    unique case (estado_q)
      OCIOSO, FIM_OK, FIM_FALHA: begin
        if (start_in) begin
          origem_d     = origem_in;
          destino_d    = destino_in;
          encontrado_d = 1'b0;
          falha_d      = 1'b0;
          estado_d     = INICIAR;
        end
      end
      INICIAR: begin
        bus.cb_atualizar_out = 1'b1;
        bus.cb_endereco_out  = origem_q;
        bus.cb_anterior_out  = origem_q;
        estado_d             = ESPERA;
      end
      ESPERA: begin
        if (!bus.aa_ocupado_in && bus.aa_pronto_in) begin
          cnt_d    = '0;
          estado_d = AVALIAR;
        end
      end
      AVALIAR: begin
        if (!bus.aa_tem_ativo_in) begin
          falha_d  = 1'b1;
          estado_d = FIM_FALHA;
        end else if (bus.aa_tem_aprovado_in) begin
          estado_d = SELECIONAR;
        end else if (cnt_q == CNT_WIDTH'(WAIT_MAX - 1)) begin
          falha_d  = 1'b1;
          estado_d = FIM_FALHA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SELECIONAR: begin
        // Approval may have been withdrawn since AVALIAR; go back and re-evaluate.
        if (|sel_onehot) begin
          sel_end_d  = sel_endereco;
          sel_dist_d = sel_distancia;
          if (sel_endereco == destino_q) begin
            encontrado_d = 1'b1;
            estado_d     = FIM_OK;
          end else begin
            estado_d = DESATIVAR;
          end
        end else begin
          estado_d = AVALIAR;
        end
      end
      DESATIVAR: begin
        bus.cb_desativar_out = 1'b1;
        bus.cb_endereco_out  = sel_end_q;
        estado_d             = EXPANDIR;
      end
      EXPANDIR, VIZINHO: begin
        bus.cb_expandir_out          = (estado_q == EXPANDIR);
        bus.cb_expandir_endereco_out = (estado_q == EXPANDIR) ? sel_end_q : '0;
        bus.cb_viz_pronto_out        = !bus.aa_ocupado_in;
        if (bus.viz_valido_in && !bus.aa_ocupado_in) begin
          viz_end_d  = bus.viz_endereco_in;
          viz_heur_d = bus.viz_heuristica_in;
          ultimo_d   = bus.viz_ultimo_in;
          viz_dist_d = DISTANCIA_WIDTH'(soma_saturada(32'(sel_dist_q), 32'(bus.viz_custo_in),
                                                      DISTANCIA_WIDTH));
          estado_d   = bus.viz_vazio_in ? ESPERA : ATUALIZAR;
        end
      end
      ATUALIZAR: begin
        bus.cb_atualizar_out     = 1'b1;
        bus.cb_endereco_out      = viz_end_q;
        bus.cb_anterior_out      = sel_end_q;
        bus.cb_distancia_out     = viz_dist_q;
        bus.cb_menor_vizinho_out = viz_heur_q;
        estado_d                 = ultimo_q ? ESPERA : VIZINHO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign cb_ocupado_out    = !(estado_q inside {OCIOSO, FIM_OK, FIM_FALHA});
  assign cb_encontrado_out = encontrado_q;
  assign cb_falha_out      = falha_q;

endmodule

// File: tb/tb_controlador_busca.sv
// Randomized bench for controlador_busca: plays evaluator and neighbour source, scores pulses.
module tb_controlador_busca;
  localparam int unsigned NUM_NA   = 4;
  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 5;
  localparam int unsigned CW       = 4;
  localparam int unsigned WAIT_MAX = 64;
  localparam int          DMAX     = (1 << DW) - 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] origem_in  = '0;
  logic [AW-1:0] destino_in = '0;
  logic          cb_ocupado_out, cb_encontrado_out, cb_falha_out;

  controlador_busca_if #(
    .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW)
  ) bus ();

  controlador_busca #(
    .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_in          (start_in),
    .origem_in         (origem_in),
    .destino_in        (destino_in),
    .cb_ocupado_out    (cb_ocupado_out),
    .cb_encontrado_out (cb_encontrado_out),
    .cb_falha_out      (cb_falha_out),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event word: kind (1 update, 2 deactivate), endereco, anterior, distancia, menor_vizinho.
  function automatic logic [31:0] mk_ev(input logic [1:0] k, input logic [AW-1:0] e,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [CW-1:0] m);
    return {11'd0, k, e, a, d, m};
  endfunction

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.cb_desativar_out && !bus.cb_atualizar_out)
      got_q.push_back(mk_ev(2'd2, bus.cb_endereco_out, '0, '0, '0));
    else if (bus.cb_atualizar_out || bus.cb_desativar_out)
      got_q.push_back(mk_ev({bus.cb_desativar_out, bus.cb_atualizar_out}, bus.cb_endereco_out,
                            bus.cb_anterior_out, bus.cb_distancia_out,
                            bus.cb_menor_vizinho_out));
  end

  function automatic logic [30:0] all_outs();
    return {bus.cb_atualizar_out, bus.cb_desativar_out, bus.cb_endereco_out, bus.cb_anterior_out,
            bus.cb_distancia_out, bus.cb_menor_vizinho_out, bus.cb_expandir_out,
            bus.cb_expandir_endereco_out, bus.cb_viz_pronto_out, cb_ocupado_out,
            cb_encontrado_out, cb_falha_out};
  endfunction

  // Trial description
  logic [AW-1:0]     t_origem, t_destino;
  logic [AW-1:0]     t_addr [NUM_NA];
  logic [DW-1:0]     t_dist [NUM_NA];
  logic [NUM_NA-1:0] t_mask;
  int                t_nviz;       // 0 means a single empty beat
  logic [AW-1:0]     v_addr  [4];
  logic [CW-1:0]     v_custo [4];
  logic [CW-1:0]     v_heur  [4];
  logic              t_ativo_fim;

  function automatic int lowest(input logic [NUM_NA-1:0] m);
    for (int i = 0; i < NUM_NA; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int sat(input int a, input int b);
    return (a + b > DMAX) ? DMAX : a + b;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < NUM_NA; i++) begin
      bus.aa_endereco_in[i*AW +: AW]  = t_addr[i];
      bus.aa_distancia_in[i*DW +: DW] = t_dist[i];
    end
    bus.aa_aprovado_in     = t_mask;
    bus.aa_tem_aprovado_in = |t_mask;
    bus.aa_tem_ativo_in    = 1'b1;
    bus.aa_ocupado_in      = 1'b0;
    bus.aa_pronto_in       = 1'b1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    drive_slots();
    origem_in  = t_origem;
    destino_in = t_destino;
    start_in   = 1'b1;
    @(negedge clk);
    start_in   = 1'b0;
    origem_in  = AW'($urandom);
    destino_in = AW'($urandom);
  endtask

  task automatic send_beats(input int n_send, input logic [AW-1:0] sa);
    int sent  = 0;
    int guard = 0;
    int busy  = $urandom_range(0, 2);
    int total = (t_nviz == 0) ? 1 : t_nviz;
    while (sent < n_send && guard < 300) begin
      @(negedge clk);
      guard++;
      bus.aa_ocupado_in = (busy > 0);
      if (busy > 0) busy--;
      bus.viz_valido_in = ($urandom_range(0, 3) != 0);
      if (t_nviz == 0) begin
        bus.viz_vazio_in      = 1'b1;
        bus.viz_ultimo_in     = 1'b1;
        bus.viz_endereco_in   = AW'($urandom);
        bus.viz_custo_in      = CW'($urandom);
        bus.viz_heuristica_in = CW'($urandom);
      end else begin
        bus.viz_vazio_in      = 1'b0;
        bus.viz_ultimo_in     = (sent == total - 1);
        bus.viz_endereco_in   = v_addr[sent];
        bus.viz_custo_in      = v_custo[sent];
        bus.viz_heuristica_in = v_heur[sent];
      end
      #1;
      if (bus.aa_ocupado_in) check_eq("pronto_while_busy", 32'(bus.cb_viz_pronto_out), 0);
      if (bus.viz_valido_in && bus.cb_viz_pronto_out) begin
        if (sent == 0)
          check_eq("expandir_req", {26'd0, bus.cb_expandir_out, bus.cb_expandir_endereco_out},
                   {26'd0, 1'b1, sa});
        sent++;
        if (t_nviz != 0) busy = $urandom_range(1, 3);
      end
    end
    if (guard >= 300) check_eq("beat_timeout", 32'(sent), 32'(n_send));
    @(negedge clk);
    bus.viz_valido_in     = 1'b0;
    bus.viz_vazio_in      = 1'b0;
    bus.viz_ultimo_in     = 1'b0;
    bus.viz_endereco_in   = AW'($urandom);
    bus.viz_custo_in      = CW'($urandom);
    bus.viz_heuristica_in = CW'($urandom);
    bus.aa_ocupado_in     = 1'b0;
  endtask

  task automatic wait_select(output int guard);
    guard = 0;
    while (!bus.cb_desativar_out && !cb_encontrado_out && !cb_falha_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_trial(input string tag);
    int          s, guard;
    logic [AW-1:0] sa;
    logic        found;
    s     = lowest(t_mask);
    sa    = t_addr[s];
    found = (sa == t_destino);
    exp_q.delete();
    exp_q.push_back(mk_ev(2'd1, t_origem, t_origem, '0, '0));
    if (!found) begin
      exp_q.push_back(mk_ev(2'd2, sa, '0, '0, '0));
      for (int i = 0; i < t_nviz; i++)
        exp_q.push_back(mk_ev(2'd1, v_addr[i], sa, DW'(sat(int'(t_dist[s]), int'(v_custo[i]))),
                              v_heur[i]));
    end
    got_q.delete();
    start_pulse();
    wait_select(guard);
    if (!found) begin
      check_eq({tag, "_deactivate"}, 32'(bus.cb_desativar_out), 1);
      bus.aa_aprovado_in     = '0;
      bus.aa_tem_aprovado_in = 1'b0;
      send_beats((t_nviz == 0) ? 1 : t_nviz, sa);
      bus.aa_tem_ativo_in = t_ativo_fim;
    end
    guard = 0;
    while (cb_ocupado_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_flags"}, {30'd0, cb_encontrado_out, cb_falha_out},
             found ? 32'd2 : 32'd1);
    check_eq({tag, "_n_events"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_trial();
    for (int i = 0; i < NUM_NA; i++) begin
      t_addr[i] = AW'(20 + i);
      t_dist[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      v_addr[i] = '0; v_custo[i] = '0; v_heur[i] = '0;
    end
  endtask

  task automatic randomize_trial();
    int s;
    t_origem  = AW'($urandom);
    t_destino = AW'($urandom);
    for (int i = 0; i < NUM_NA; i++) begin
      t_addr[i] = AW'($urandom);
      t_dist[i] = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(24, 31)) : DW'($urandom);
    end
    do t_mask = NUM_NA'($urandom); while (t_mask == '0);
    s = lowest(t_mask);
    if ($urandom_range(0, 2) == 0) t_addr[s] = t_destino;
    else if (t_addr[s] == t_destino) t_addr[s] = t_destino + 1'b1;
    t_nviz = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      v_addr[i]  = AW'($urandom);
      v_custo[i] = CW'($urandom);
      v_heur[i]  = CW'($urandom);
    end
    t_ativo_fim = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int guard;
    bus.aa_aprovado_in     = '0;
    bus.aa_endereco_in     = '0;
    bus.aa_distancia_in    = '0;
    bus.aa_tem_ativo_in    = 1'b0;
    bus.aa_tem_aprovado_in = 1'b0;
    bus.aa_ocupado_in      = 1'b0;
    bus.aa_pronto_in       = 1'b1;
    bus.viz_valido_in      = 1'b0;
    bus.viz_vazio_in       = 1'b0;
    bus.viz_endereco_in    = '0;
    bus.viz_custo_in       = '0;
    bus.viz_heuristica_in  = '0;
    bus.viz_ultimo_in      = 1'b0;

    #12;
    check_eq("reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Origin is already the destination.
    clear_trial();
    t_origem = 5'd3; t_destino = 5'd3; t_addr[0] = 5'd3; t_mask = 4'b0001;
    t_nviz = 0; t_ativo_fim = 1'b0;
    run_trial("origin_is_dest");

    // Two neighbours of node 5 at distance 4, then no active nodes left.
    clear_trial();
    t_origem = 5'd1; t_destino = 5'd20; t_addr[0] = 5'd5; t_dist[0] = 5'd4; t_mask = 4'b0001;
    t_nviz = 2;
    v_addr[0] = 5'd7; v_custo[0] = 4'd2; v_heur[0] = 4'd3;
    v_addr[1] = 5'd9; v_custo[1] = 4'd3; v_heur[1] = 4'd8;
    t_ativo_fim = 1'b0;
    run_trial("two_neighbours");

    // Distance saturation, then starvation timeout.
    clear_trial();
    t_origem = 5'd0; t_destino = 5'd1; t_addr[2] = 5'd10; t_dist[2] = 5'd30; t_mask = 4'b0100;
    t_nviz = 1; v_addr[0] = 5'd4; v_custo[0] = 4'd5; v_heur[0] = 4'd1;
    t_ativo_fim = 1'b1;
    run_trial("saturate");

    // Priority: slot 1 beats slot 3 (slot 3 would be a false hit).
    clear_trial();
    t_origem = 5'd2; t_destino = 5'd13; t_addr[1] = 5'd12; t_addr[3] = 5'd13; t_mask = 4'b1010;
    t_nviz = 0; t_ativo_fim = 1'b0;
    run_trial("priority");

    // Exact starvation timing with active but never approved slots.
    clear_trial();
    t_origem = 5'd4; t_destino = 5'd8; t_mask = '0;
    @(negedge clk);
    drive_slots();
    origem_in = t_origem; destino_in = t_destino; start_in = 1'b1;
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      start_in = 1'b0;
      if (k == 66) check_eq("timeout_before", {30'd0, cb_ocupado_out, cb_falha_out}, 32'd2);
      if (k == 67) check_eq("timeout_at", {30'd0, cb_ocupado_out, cb_falha_out}, 32'd1);
    end

    // Asynchronous reset while in VIZINHO, then a clean rerun.
    clear_trial();
    t_origem = 5'd1; t_destino = 5'd20; t_addr[0] = 5'd5; t_dist[0] = 5'd4; t_mask = 4'b0001;
    t_nviz = 2;
    v_addr[0] = 5'd7; v_custo[0] = 4'd2; v_heur[0] = 4'd3;
    v_addr[1] = 5'd9; v_custo[1] = 4'd3; v_heur[1] = 4'd8;
    t_ativo_fim = 1'b0;
    start_pulse();
    wait_select(guard);
    bus.aa_aprovado_in     = '0;
    bus.aa_tem_aprovado_in = 1'b0;
    send_beats(1, 5'd5);
    @(negedge clk);
    check_eq("mid_search_busy", 32'(cb_ocupado_out), 1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_slots();
    run_trial("after_reset");

    for (int t = 0; t < 30; t++) begin
      randomize_trial();
      run_trial($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_busca.md
Name: controlador_busca

Overview:
Sequencing controller for the active-node evaluator (avaliador_ativos) in the path-search accelerator.
- Seeds the search with the origin node and waits for classification to settle.
- Selects an approved node, retires it, fetches its neighbours from the neighbour source and pushes each one back into the evaluator as an update.
- Ends with found or fail status.

Parameters:
NUM_NA, 4, number of active-node slots in the evaluator
ADDR_WIDTH, 5, node address width
DISTANCIA_WIDTH, 5, accumulated distance width
CUSTO_WIDTH, 4, edge cost / heuristic width
WAIT_MAX, 64, cycles allowed in AVALIAR without an approved node before failing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_in  in  1  start pulse, sampled only in OCIOSO, FIM_OK or FIM_FALHA
origem_in  in  ADDR_WIDTH  source node, latched at start
destino_in  in  ADDR_WIDTH  target node, latched at start
aa_aprovado_in  in  NUM_NA  approved flags per slot
aa_endereco_in  in  ADDR_WIDTH*NUM_NA  slot addresses, flattened, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  slot distances, flattened the same way
aa_tem_ativo_in  in  1  any slot active
aa_tem_aprovado_in  in  1  any slot approved
aa_ocupado_in  in  1  evaluator busy
aa_pronto_in  in  1  classification settled
cb_atualizar_out  out  1  one-cycle update pulse to evaluator
cb_desativar_out  out  1  one-cycle deactivate pulse to evaluator
cb_endereco_out  out  ADDR_WIDTH  address for update/deactivate
cb_anterior_out  out  ADDR_WIDTH  predecessor for update
cb_distancia_out  out  DISTANCIA_WIDTH  distance for update
cb_menor_vizinho_out  out  CUSTO_WIDTH  heuristic for update
cb_expandir_out  out  1  neighbour request, held until first neighbour beat
cb_expandir_endereco_out  out  ADDR_WIDTH  node to expand
viz_valido_in  in  1  neighbour beat valid
viz_vazio_in  in  1  beat carries no neighbour; only legal when viz_ultimo_in=1
viz_endereco_in  in  ADDR_WIDTH  neighbour address
viz_custo_in  in  CUSTO_WIDTH  edge cost
viz_heuristica_in  in  CUSTO_WIDTH  neighbour heuristic
viz_ultimo_in  in  1  last neighbour of this expansion
cb_viz_pronto_out  out  1  ready for neighbour beat
cb_ocupado_out  out  1  search in progress
cb_encontrado_out  out  1  destination reached; held until next start
cb_falha_out  out  1  search failed; held until next start

Behaviour:
- Reset: all outputs 0; state OCIOSO. Reset mid-search aborts immediately; no flush pulses are issued.
- OCIOSO/FIM_*: on start_in, latch origem_in and destino_in, clear both flags, go to INICIAR.
- INICIAR: one cycle.
  - cb_atualizar_out=1, endereco=origem, anterior=origem, distancia=0, menor_vizinho=0.
  - Go to ESPERA.
- ESPERA: wait until aa_ocupado_in=0 and aa_pronto_in=1, then go to AVALIAR. The wait counter is cleared on entry to AVALIAR.
- AVALIAR:
  - aa_tem_ativo_in=0 -> FIM_FALHA.
  - aa_tem_aprovado_in=1 -> SELECIONAR.
  - Otherwise count cycles; after WAIT_MAX cycles -> FIM_FALHA.
- SELECIONAR: lowest-index set bit of aa_aprovado_in is the selected slot.
  - Latch the slot's address and distance.
  - If address==destino -> FIM_OK, cb_encontrado_out=1.
  - Otherwise -> DESATIVAR.
- DESATIVAR: one cycle; cb_desativar_out=1 with cb_endereco_out=selected address. Go to EXPANDIR.
- EXPANDIR:
  - cb_expandir_out=1 and cb_expandir_endereco_out=selected address, held until the first beat is accepted.
  - cb_viz_pronto_out=1 while aa_ocupado_in=0.
  - A beat is accepted when viz_valido_in & cb_viz_pronto_out.
- On acceptance of a non-empty beat, drive ATUALIZAR on the next cycle:
  - cb_atualizar_out=1, endereco=viz_endereco_in, anterior=selected address, menor_vizinho=viz_heuristica_in.
  - distancia = selected distance + viz_custo_in, zero-extended, saturating at 2^DISTANCIA_WIDTH-1.
- After ATUALIZAR: cb_viz_pronto_out=0 until aa_ocupado_in drops.
  - Last beat -> ESPERA.
  - Otherwise -> VIZINHO. VIZINHO accepts further beats under the same rules as EXPANDIR.
- Empty beat (viz_vazio_in=1, viz_ultimo_in=1): no update; go straight to ESPERA.
- Beat data is registered on acceptance; the source may change its inputs afterwards.
- cb_ocupado_out=1 in every state except OCIOSO, FIM_OK and FIM_FALHA.
- cb_atualizar_out and cb_desativar_out are never asserted in the same cycle.

Decomposition:
- Package cb_pkg holds:
  - the state enumeration (OCIOSO, INICIAR, ESPERA, AVALIAR, SELECIONAR, DESATIVAR, EXPANDIR, VIZINHO, ATUALIZAR, FIM_OK, FIM_FALHA);
  - a saturating-add function parameterised by width.
- One sub-module, seletor_aprovado: combinational lowest-index priority encoder producing a one-hot vector plus the mux of address and distance from the flattened buses.

Test Plan:
- Origem 3 == destino 3; evaluator approves slot 0 at address 3 -> exactly one update pulse (endereco 3, distancia 0), no deactivate pulse, cb_encontrado_out=1.
- Selected node 5 with distance 4; neighbours (7, custo 2) and (9, custo 3, ultimo) -> deactivate(5), then updates (7, anterior 5, distancia 6) and (9, anterior 5, distancia 7).
- Distance 30 plus custo 5 at DISTANCIA_WIDTH=5 -> cb_distancia_out=31 (saturated).
- aa_aprovado_in=4'b1010 -> slot 1 selected, cb_endereco_out equals slot 1's address.
- aa_tem_ativo_in=0 in AVALIAR -> cb_falha_out=1. Separately, active slots but no approval held for 64 cycles -> cb_falha_out=1.
- rst_n asserted during VIZINHO -> all outputs 0 asynchronously; a new start afterwards runs cleanly from INICIAR.
